// File: rtl/sfu.sv
// sfu - special function unit below the systolic array.
// Keeps one running accumulator per column, loading on the first cycle of an
// acc_i burst and adding on later cycles. The updated value is presented raw
// (mode_i=1) or ReLU-clipped (mode_i=0) on a registered output bus.
// Build option: define SFU_SAT_EN to saturate accumulation on signed overflow;
// the default build wraps modulo 2^psum_bw.
module sfu #(
   parameter int bw      = 4,
   parameter int col     = 8,
   parameter int row     = 8,
   parameter int psum_bw = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     acc_i,
   input  logic                     mode_i,
   input  logic [psum_bw*col-1:0]   psum_in,
   output logic [psum_bw*col-1:0]   psum_out
);

   localparam int MSB = psum_bw - 1;

   // bw and row describe the surrounding array only; no logic depends on them.
   if (bw < 1 || row < 1) begin : g_array_dims_unused
   end

   // Accumulate one column value; overflow either wraps or clamps.
   function automatic logic [psum_bw-1:0] acc_add(
      input logic [psum_bw-1:0] a,
      input logic [psum_bw-1:0] b
   );
      logic [psum_bw-1:0] sum;
      sum = a + b;
`ifdef SFU_SAT_EN
      if ((a[MSB] == b[MSB]) && (sum[MSB] != a[MSB])) begin
         // Both operands share a sign the result lost: clamp toward that sign.
         sum = a[MSB] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
      end
`endif
      return sum;
   endfunction

   // ReLU passes non-negative values, zeroes negatives; distance mode is raw.
   function automatic logic [psum_bw-1:0] out_fn(
      input logic               raw_mode,
      input logic [psum_bw-1:0] v
   );
      logic [psum_bw-1:0] r;
      r = v;
      if (!raw_mode && v[MSB]) begin
         r = '0;
      end
      return r;
   endfunction

   logic [col-1:0][psum_bw-1:0] acc_q;
   logic [col-1:0][psum_bw-1:0] acc_d;
   logic [col-1:0][psum_bw-1:0] psum_in_w;
   logic [col-1:0][psum_bw-1:0] out_q;
   logic [col-1:0][psum_bw-1:0] out_d;
   logic                        acc_prev_q;

   assign psum_in_w = psum_in;
   assign psum_out  = out_q;

   // Next accumulator value and output function, per column.
   always_comb begin
      acc_d = acc_q;
      out_d = '0;
      for (int c = 0; c < col; c++) begin
         if (acc_i) begin
            // A burst start reloads so stale sums from a previous burst never leak in.
            acc_d[c] = acc_prev_q ? acc_add(acc_q[c], psum_in_w[c]) : psum_in_w[c];
         end
         out_d[c] = out_fn(mode_i, acc_d[c]);
      end
   end

   // Accumulators, burst tracker and output register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q      <= '0;
         out_q      <= '0;
         acc_prev_q <= 1'b0;
      end else begin
         acc_q      <= acc_d;
         out_q      <= out_d;
         acc_prev_q <= acc_i;
      end
   end

endmodule

// File: tb/tb_sfu.sv
module tb_sfu;
   localparam int COL = 8;
   localparam int PBW = 16;
   localparam int W   = COL * PBW;

   logic         clk = 1'b0;
   logic         reset;
   logic         acc_i;
   logic         mode_i;
   logic [W-1:0] psum_in;
   logic [W-1:0] psum_out;

   int errors = 0;
   int checks = 0;

   // Reference model: signed integer accumulators and a burst flag.
   int acc_m [COL];
   bit in_burst_m;

   sfu #(.bw(4), .col(COL), .row(8), .psum_bw(PBW)) dut (
      .clk      (clk),
      .reset    (reset),
      .acc_i    (acc_i),
      .mode_i   (mode_i),
      .psum_in  (psum_in),
      .psum_out (psum_out)
   );

   always #5 clk = ~clk;

   function automatic int to_signed16(input int v);
      int r;
      r = v % 65536;
      if (r < 0) r += 65536;
      if (r >= 32768) r -= 65536;
      return r;
   endfunction

   function automatic int model_add(input int a, input int b);
      int s;
      s = a + b;
`ifdef SFU_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return s;
`else
      return to_signed16(s);
`endif
   endfunction

   function automatic logic [W-1:0] model_out(input logic m);
      logic [W-1:0] v;
      int           y;
      v = '0;
      for (int c = 0; c < COL; c++) begin
         y = acc_m[c];
         if (!m && y < 0) y = 0;
         v[c*PBW +: PBW] = 16'(y);
      end
      return v;
   endfunction

   function automatic logic [W-1:0] splat(input logic [15:0] v);
      logic [W-1:0] r;
      for (int c = 0; c < COL; c++) r[c*PBW +: PBW] = v;
      return r;
   endfunction

   task automatic check_bus(input string tag, input logic [W-1:0] exp_v);
      checks++;
      assert (psum_out === exp_v) else begin
         errors++;
         $error("FAIL %s: psum_out=%h expected=%h", tag, psum_out, exp_v);
      end
   endtask

   // Drive one row, clock it in, advance the model and compare.
   task automatic step(input logic a, input logic m, input logic [W-1:0] v, input string tag);
      int x;
      acc_i   = a;
      mode_i  = m;
      psum_in = v;
      @(posedge clk);
      #1;
      if (a) begin
         for (int c = 0; c < COL; c++) begin
            x = to_signed16(int'(v[c*PBW +: PBW]));
            acc_m[c] = in_burst_m ? model_add(acc_m[c], x) : x;
         end
      end
      in_burst_m = a;
      check_bus(tag, model_out(m));
   endtask

   task automatic model_reset();
      for (int c = 0; c < COL; c++) acc_m[c] = 0;
      in_burst_m = 1'b0;
   endtask

   initial begin
      logic [W-1:0] v;
      logic [W-1:0] exp_v;
      reset   = 1'b1;
      acc_i   = 1'b1;
      mode_i  = 1'b1;
      psum_in = splat(16'h1234);
      model_reset();

      // Reset held while driving a burst: output stays zero.
      #1;
      check_bus("reset_t0", '0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check_bus("reset_held", '0);
      end
      reset = 1'b0;
      step(1'b1, 1'b1, splat(16'h1234), "reset_release_load");
      exp_v = splat(16'h1234);
      check_bus("reset_release_const", exp_v);

      // Burst accumulate in distance mode.
      step(1'b0, 1'b1, '0, "gap0");
      step(1'b1, 1'b1, splat(16'h0001), "burst_1");
      step(1'b1, 1'b1, splat(16'h0002), "burst_3");
      step(1'b1, 1'b1, splat(16'h0003), "burst_6");
      exp_v = splat(16'h0006);
      check_bus("burst_6_const", exp_v);

      // Hold, then restart reloads.
      step(1'b0, 1'b1, splat(16'h5555), "hold_a");
      step(1'b0, 1'b1, splat(16'h5555), "hold_b");
      step(1'b1, 1'b1, splat(16'h0010), "restart_reload");
      exp_v = splat(16'h0010);
      check_bus("restart_reload_const", exp_v);

      // ReLU on a negative and positive column, then raw on the held value.
      step(1'b0, 1'b0, '0, "gap1");
      v = '0;
      v[0*PBW +: PBW] = 16'hFFF0;
      v[1*PBW +: PBW] = 16'h0020;
      step(1'b1, 1'b0, v, "relu_load");
      exp_v = '0;
      exp_v[1*PBW +: PBW] = 16'h0020;
      check_bus("relu_const", exp_v);
      step(1'b0, 1'b1, '0, "relu_hold_raw");
      exp_v[0*PBW +: PBW] = 16'hFFF0;
      check_bus("raw_hold_const", exp_v);
      step(1'b0, 1'b0, '0, "relu_hold_again");

      // Column independence.
      v = '0;
      for (int c = 0; c < COL; c++) v[c*PBW +: PBW] = 16'(c + 1);
      step(1'b1, 1'b1, v, "cols_load");
      step(1'b1, 1'b1, v, "cols_twice");
      for (int c = 0; c < COL; c++) exp_v[c*PBW +: PBW] = 16'(2 * (c + 1));
      check_bus("cols_const", exp_v);

      // Overflow in both directions.
      step(1'b0, 1'b1, '0, "gap2");
      v = splat(16'h7FFF);
      v[1*PBW +: PBW] = 16'h8000;
      step(1'b1, 1'b1, v, "ovf_load");
      v = splat(16'h0001);
      v[1*PBW +: PBW] = 16'hFFFF;
      step(1'b1, 1'b1, v, "ovf_add");
      exp_v = splat(
`ifdef SFU_SAT_EN
         16'h7FFF
`else
         16'h8000
`endif
      );
      exp_v[1*PBW +: PBW] =
`ifdef SFU_SAT_EN
         16'h8000;
`else
         16'h7FFF;
`endif
      check_bus("ovf_const", exp_v);

      // Asynchronous reset mid-burst, then the next acc_i=1 reloads.
      step(1'b1, 1'b1, splat(16'h0100), "pre_async");
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check_bus("async_reset", '0);
      #1;
      reset = 1'b0;
      step(1'b1, 1'b1, splat(16'h0042), "post_async_reload");

      // Randomised traffic against the model.
      for (int i = 0; i < 300; i++) begin
         for (int c = 0; c < COL; c++) v[c*PBW +: PBW] = 16'($urandom);
         if ((i % 50) == 7) v = splat(16'h7FF0);
         step(($urandom_range(0, 9) < 7), 1'($urandom), v, "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
